// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the axis move sequencer and its step movers.
package move_sequencer_pkg;

  // Position / step-count width, common to the sequencer and both movers.
  localparam int STEP_W = 12;

  // Coil pattern held on the motor pins before any move has completed.
  localparam logic [3:0] COIL_DEFAULT = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/move_delta.sv
// Combinational move planner: direction, step count, no-op and range check
// for an absolute target relative to the current position.
module move_delta
  import move_sequencer_pkg::*;
#(
  parameter logic [STEP_W-1:0] MAX_POS = 12'd3000
) (
  input  logic [STEP_W-1:0] target,
  input  logic [STEP_W-1:0] position,
  output logic              dir_fwd,
  output logic [STEP_W-1:0] steps,
  output logic              zero,
  output logic              out_of_range
);

  // Compare and subtract in whichever order keeps the step count non-negative.
  always_comb begin
    dir_fwd      = (target > position);
    steps        = dir_fwd ? (target - position) : (position - target);
    zero         = (target == position);
    out_of_range = (target > MAX_POS);
  end

endmodule

// File: rtl/move_sequencer.sv
// Command-side initiator for one motor axis: plans each move, launches the
// forward or reverse step mover, tracks absolute position and keeps the coil
// phase continuous between moves by feeding back the last held pattern.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter logic [STEP_W-1:0] MAX_POS    = 12'd3000,
  parameter logic [STEP_W-1:0] HOME_STEPS = 12'd4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_home,
  input  logic [STEP_W-1:0] cmd_target,
  output logic              fwd_go,
  output logic              rev_go,
  output logic [STEP_W-1:0] mv_steps,
  input  logic              fwd_done,
  input  logic              rev_done,
  input  logic [3:0]        fwd_state,
  input  logic [3:0]        rev_state,
  output logic [3:0]        held_state,
  output logic [3:0]        coil_out,
  input  logic              lim_lo,
  input  logic              lim_hi,
  output logic [STEP_W-1:0] position,
  output logic              busy,
  output logic              cmd_done,
  output logic              err
);

  state_e              state_q, state_d;
  logic                fwd_go_q, fwd_go_d;
  logic                rev_go_q, rev_go_d;
  logic [STEP_W-1:0]   mv_steps_q, mv_steps_d;
  logic [3:0]          held_state_q, held_state_d;
  logic [STEP_W-1:0]   position_q, position_d;
  logic                cmd_done_q, cmd_done_d;
  logic                err_q, err_d;
  logic                home_q, home_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic                active_fwd_q, active_fwd_d;

  logic                dlt_fwd;
  logic [STEP_W-1:0]   dlt_steps;
  logic                dlt_zero;
  logic                dlt_oor;
  logic                active_done;

  move_delta #(.MAX_POS(MAX_POS)) u_delta (
    .target       (target_q),
    .position     (position_q),
    .dir_fwd      (dlt_fwd),
    .steps        (dlt_steps),
    .zero         (dlt_zero),
    .out_of_range (dlt_oor)
  );

  // Only the mover that was launched can end the move; the other done is ignored.
  assign active_done = active_fwd_q ? fwd_done : rev_done;

  // Next-state, launch and completion bookkeeping.
  always_comb begin
    // NOTE: every _d takes its held value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    fwd_go_d     = fwd_go_q;
    rev_go_d     = rev_go_q;
    mv_steps_d   = mv_steps_q;
    held_state_d = held_state_q;
    position_d   = position_q;
    cmd_done_d   = 1'b0;
    err_d        = err_q;
    home_d       = home_q;
    target_d     = target_q;
    active_fwd_d = active_fwd_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_d    = 1'b0;
          home_d   = cmd_home;
          target_d = cmd_target;
          state_d  = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (home_q) begin
          rev_go_d     = 1'b1;
          active_fwd_d = 1'b0;
          mv_steps_d   = HOME_STEPS;
          state_d      = ST_WAIT;
        end else if (dlt_oor) begin
          err_d      = 1'b1;
          cmd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (dlt_zero) begin
          cmd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          fwd_go_d     = dlt_fwd;
          rev_go_d     = !dlt_fwd;
          active_fwd_d = dlt_fwd;
          mv_steps_d   = dlt_steps;
          state_d      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (active_done) begin
          fwd_go_d     = 1'b0;
          rev_go_d     = 1'b0;
          held_state_d = active_fwd_q ? fwd_state : rev_state;
          state_d      = ST_RELEASE;
          if (active_fwd_q) begin
            if (lim_hi) begin
              position_d = MAX_POS;
              err_d      = 1'b1;
            end else begin
              position_d = target_q;
            end
          end else if (lim_lo) begin
            position_d = '0;
            err_d      = !home_q;
          end else if (home_q) begin
            err_d = 1'b1;
          end else begin
            position_d = target_q;
          end
        end
      end

      ST_RELEASE: begin
        // Hold here until the mover has dropped done, so it is reset before reuse.
        if (!active_done) begin
          cmd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // value of the others, independent of statement order.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fwd_go_q     <= 1'b0;
      rev_go_q     <= 1'b0;
      mv_steps_q   <= '0;
      held_state_q <= COIL_DEFAULT;
      position_q   <= '0;
      cmd_done_q   <= 1'b0;
      err_q        <= 1'b0;
      home_q       <= 1'b0;
      target_q     <= '0;
      active_fwd_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fwd_go_q     <= fwd_go_d;
      rev_go_q     <= rev_go_d;
      mv_steps_q   <= mv_steps_d;
      held_state_q <= held_state_d;
      position_q   <= position_d;
      cmd_done_q   <= cmd_done_d;
      err_q        <= err_d;
      home_q       <= home_d;
      target_q     <= target_d;
      active_fwd_q <= active_fwd_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign fwd_go     = fwd_go_q;
  assign rev_go     = rev_go_q;
  assign mv_steps   = mv_steps_q;
  assign held_state = held_state_q;
  assign position   = position_q;
  assign cmd_done   = cmd_done_q;
  assign err        = err_q;
  // Drive the motor from whichever mover is running, else hold the last phase.
  assign coil_out   = fwd_go_q ? fwd_state : (rev_go_q ? rev_state : held_state_q);

endmodule
